// File: rtl/scan_pkg.sv
// Shared definitions for the multiplexed display scanner, segment decoder
// and board top: width helpers and the all-anodes-off mask.

`ifndef SCAN_IDX_W
// Width of a digit index for an n-digit display (never narrower than 1 bit).
`define SCAN_IDX_W(n) scan_pkg::clog2(n)
`endif

package scan_pkg;

  // Widest display the anode-mask helper supports.
  localparam int MAX_DIGITS = 64;

  // Blink phase of the selected digits.
  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_HIDDEN  = 1'b1
  } blink_phase_e;

  // Bits needed to hold 0..n-1, with a floor of 1 so degenerate counters
  // still have a real register behind them.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Anode pattern with the low n bits set (all anodes off, active low).
  function automatic logic [MAX_DIGITS-1:0] an_off_mask(input int n);
    logic [MAX_DIGITS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Generic mod-N counter with enable. Exposes the next count so a consumer can
// register outputs that line up with the counter on the same edge.

module scan_prescaler
  import scan_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         tick
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // Next count: wrap on terminal count, otherwise step while enabled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    tick    = en && (cnt == LAST);
    cnt_nxt = cnt;
    if (tick)    cnt_nxt = '0;
    else if (en) cnt_nxt = cnt + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/scan_display_ctrl.sv
// Self-timed multiplexed display scanner: prescaler-driven digit scan,
// per-frame shadow latching of display data, anti-ghost dead time at the
// start of each slot, and per-digit blinking. All outputs are registered
// from next-state values so anode and data never skew.

module scan_display_ctrl
  import scan_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYC     = 64,
  parameter int BLINK_FRAMES = 256,
  parameter bit FRAME_SYNC   = 1'b1,
  localparam int SW          = `SCAN_IDX_W(DIGITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [4*DIGITS-1:0] hexs,
  input  logic [DIGITS-1:0]   point,
  input  logic [DIGITS-1:0]   les,
  output logic [3:0]          hexo,
  output logic                p,
  output logic                le,
  output logic [DIGITS-1:0]   an,
  output logic [SW-1:0]       scan
);

  localparam int CW = clog2(SCAN_DIV);
  localparam int FW = clog2(BLINK_FRAMES);

  localparam logic [SW-1:0]         SCAN_LAST  = SW'(DIGITS - 1);
  localparam logic [FW-1:0]         FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [MAX_DIGITS-1:0] AN_OFF_W   = an_off_mask(DIGITS);
  localparam logic [DIGITS-1:0]     AN_OFF     = AN_OFF_W[DIGITS-1:0];

  // Slot prescaler.
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          tick;

  scan_prescaler #(
    .N (SCAN_DIV),
    .W (CW)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cnt     (cnt),
    .cnt_nxt (cnt_nxt),
    .tick    (tick)
  );

  // State registers and their next values.
  logic [SW-1:0]       scan_nxt;
  logic                wrap;
  logic [FW-1:0]       frame_cnt, frame_nxt;
  blink_phase_e        phase, phase_nxt;
  logic [4*DIGITS-1:0] hexs_sh, hexs_sh_nxt;
  logic [DIGITS-1:0]   point_sh, point_sh_nxt;
  logic [DIGITS-1:0]   les_sh, les_sh_nxt;

  // Output next values.
  logic [DIGITS-1:0]   sel;
  logic [DIGITS-1:0]   an_nxt;
  logic [3:0]          hexo_nxt;
  logic                blank_nxt;

  // Digit counter: advance on tick, flag the frame wrap on the last digit.
  always_comb begin
    scan_nxt = scan;
    wrap     = 1'b0;
    if (tick) begin
      if (scan == SCAN_LAST) begin
        scan_nxt = '0;
        wrap     = 1'b1;
      end else begin
        scan_nxt = scan + 1'b1;
      end
    end
  end

  // Shadow load: once per frame for tear-free data, or every enabled cycle.
  always_comb begin
    hexs_sh_nxt  = hexs_sh;
    point_sh_nxt = point_sh;
    les_sh_nxt   = les_sh;
    if (FRAME_SYNC ? wrap : en) begin
      hexs_sh_nxt  = hexs;
      point_sh_nxt = point;
      les_sh_nxt   = les;
    end
  end

  // Blink timing: count frames, flip the phase every BLINK_FRAMES frames.
  always_comb begin
    frame_nxt = frame_cnt;
    phase_nxt = phase;
    if (wrap) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_nxt = '0;
        phase_nxt = (phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        frame_nxt = frame_cnt + 1'b1;
      end
    end
  end

  // Output decode from the post-edge state so anode and data switch together.
  always_comb begin
    sel           = '0;
    sel[scan_nxt] = 1'b1;
    blank_nxt     = (int'(cnt_nxt) < DEAD_CYC) ||
                    (les_sh_nxt[scan_nxt] && (phase_nxt == PH_HIDDEN));
    an_nxt        = blank_nxt ? AN_OFF : ~sel;
    hexo_nxt      = hexs_sh_nxt[{scan_nxt, 2'b00} +: 4];
  end

  // State and output registers; everything holds while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shadow registers are reset too, so the first frame after
    // reset shows zeros with all decoders in a known state rather than X.
    if (!rst_n) begin
      scan      <= '0;
      frame_cnt <= '0;
      phase     <= PH_VISIBLE;
      hexs_sh   <= '0;
      point_sh  <= '0;
      les_sh    <= '0;
      an        <= AN_OFF;
      hexo      <= '0;
      p         <= 1'b0;
      le        <= 1'b0;
    end else if (en) begin
      scan      <= scan_nxt;
      frame_cnt <= frame_nxt;
      phase     <= phase_nxt;
      hexs_sh   <= hexs_sh_nxt;
      point_sh  <= point_sh_nxt;
      les_sh    <= les_sh_nxt;
      an        <= an_nxt;
      hexo      <= hexo_nxt;
      p         <= point_sh_nxt[scan_nxt];
      le        <= les_sh_nxt[scan_nxt];
    end
  end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl: a 4-digit instance and a 1-digit
// instance, both with a 4-cycle slot, 1 dead cycle and 2-frame blink.

module tb_scan_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;

  // 4-digit instance
  logic [15:0] hexs = '0;
  logic [3:0]  point = '0;
  logic [3:0]  les = '0;
  logic [3:0]  hexo;
  logic        p;
  logic        le;
  logic [3:0]  an;
  logic [1:0]  scan;

  // 1-digit instance
  logic [3:0]  hexs1 = '0;
  logic        point1 = 1'b0;
  logic        les1 = 1'b0;
  logic [3:0]  hexo1;
  logic        p1;
  logic        le1;
  logic        an1;
  logic        scan1;

  int checks  = 0;
  int errors  = 0;
  int edge_no = 0;

  always #5 clk = ~clk;

  scan_display_ctrl #(
    .DIGITS       (4),
    .SCAN_DIV     (4),
    .DEAD_CYC     (1),
    .BLINK_FRAMES (2),
    .FRAME_SYNC   (1'b1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .hexs  (hexs),
    .point (point),
    .les   (les),
    .hexo  (hexo),
    .p     (p),
    .le    (le),
    .an    (an),
    .scan  (scan)
  );

  scan_display_ctrl #(
    .DIGITS       (1),
    .SCAN_DIV     (4),
    .DEAD_CYC     (1),
    .BLINK_FRAMES (2),
    .FRAME_SYNC   (1'b1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .hexs  (hexs1),
    .point (point1),
    .les   (les1),
    .hexo  (hexo1),
    .p     (p1),
    .le    (le1),
    .an    (an1),
    .scan  (scan1)
  );

  // Observed vectors: {scan, an, hexo, p, le}
  wire [11:0] obs  = {scan, an, hexo, p, le};
  wire [7:0]  obs1 = {scan1, an1, hexo1, p1, le1};

  // Advance to just after posedge number n since the last reset release.
  task automatic run_to(input int n);
    while (edge_no < n) begin
      @(posedge clk);
      #1;
      edge_no++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n   = 1'b1;
    edge_no = 0;
  endtask

  task automatic test_reset();
    hexs = 16'h1234; point = '0; les = '0;
    hexs1 = 4'h7; point1 = 1'b1; les1 = 1'b0; en = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checks++;
    if (obs !== {2'd0, 4'b1111, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset4 got %b exp %b", obs, {2'd0, 4'b1111, 4'h0, 1'b0, 1'b0});
    end
    checks++;
    if (obs1 !== {1'b0, 1'b1, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset1 got %b exp %b", obs1, {1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst_n   = 1'b1;
    edge_no = 0;
  endtask

  // Frame 0 shows reset shadow; after the wrap at edge 16 digits follow 1234.
  task automatic test_scan();
    int          e [7] = '{5, 16, 17, 19, 25, 28, 29};
    logic [11:0] x [7] = '{
      {2'd1, 4'b1101, 4'h0, 1'b0, 1'b0},
      {2'd0, 4'b1111, 4'h4, 1'b0, 1'b0},
      {2'd0, 4'b1110, 4'h4, 1'b0, 1'b0},
      {2'd0, 4'b1110, 4'h4, 1'b0, 1'b0},
      {2'd2, 4'b1011, 4'h2, 1'b1, 1'b0},
      {2'd3, 4'b1111, 4'h1, 1'b0, 1'b0},
      {2'd3, 4'b0111, 4'h1, 1'b0, 1'b0}
    };
    hexs = 16'h1234; point = 4'b0100; les = '0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      run_to(e[i]);
      checks++;
      if (obs !== x[i]) begin
        errors++;
        $display("FAIL scan_edge%0d got %b exp %b", e[i], obs, x[i]);
      end
    end
  endtask

  // Mid-frame data change stays invisible until the next wrap.
  task automatic test_shadow();
    int          e [4] = '{29, 33, 37, 45};
    logic [11:0] x [4] = '{
      {2'd3, 4'b0111, 4'h1, 1'b0, 1'b0},
      {2'd0, 4'b1110, 4'hD, 1'b0, 1'b0},
      {2'd1, 4'b1101, 4'hC, 1'b0, 1'b0},
      {2'd3, 4'b0111, 4'hA, 1'b0, 1'b0}
    };
    hexs = 16'h1234; point = '0; les = '0;
    do_reset();
    run_to(20);
    hexs = 16'hABCD;
    for (int i = 0; i < 4; i++) begin
      run_to(e[i]);
      checks++;
      if (obs !== x[i]) begin
        errors++;
        $display("FAIL shadow_edge%0d got %b exp %b", e[i], obs, x[i]);
      end
    end
  endtask

  // Digit 0 blinks: visible frames 0-1, hidden 2-3, period 64 cycles.
  task automatic test_blink();
    int          e [7] = '{17, 33, 37, 49, 65, 81, 97};
    logic [11:0] x [7] = '{
      {2'd0, 4'b1110, 4'h4, 1'b0, 1'b1},
      {2'd0, 4'b1111, 4'h4, 1'b0, 1'b1},
      {2'd1, 4'b1101, 4'h3, 1'b0, 1'b0},
      {2'd0, 4'b1111, 4'h4, 1'b0, 1'b1},
      {2'd0, 4'b1110, 4'h4, 1'b0, 1'b1},
      {2'd0, 4'b1110, 4'h4, 1'b0, 1'b1},
      {2'd0, 4'b1111, 4'h4, 1'b0, 1'b1}
    };
    hexs = 16'h1234; point = '0; les = 4'b0001;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      run_to(e[i]);
      checks++;
      if (obs !== x[i]) begin
        errors++;
        $display("FAIL blink_edge%0d got %b exp %b", e[i], obs, x[i]);
      end
    end
  endtask

  // Freeze at scan=2, cnt=1 for 10 cycles; resume reaches the tick 3 edges later.
  task automatic test_enable();
    logic [11:0] hold_v;
    hold_v = {2'd2, 4'b1011, 4'h2, 1'b0, 1'b0};
    hexs = 16'h1234; point = '0; les = '0;
    do_reset();
    run_to(25);
    checks++;
    if (obs !== hold_v) begin
      errors++;
      $display("FAIL en_before got %b exp %b", obs, hold_v);
    end
    en = 1'b0;
    run_to(30);
    checks++;
    if (obs !== hold_v) begin
      errors++;
      $display("FAIL en_hold_mid got %b exp %b", obs, hold_v);
    end
    run_to(35);
    checks++;
    if (obs !== hold_v) begin
      errors++;
      $display("FAIL en_hold_end got %b exp %b", obs, hold_v);
    end
    en = 1'b1;
    run_to(37);
    checks++;
    if (obs !== hold_v) begin
      errors++;
      $display("FAIL en_resume_cnt3 got %b exp %b", obs, hold_v);
    end
    run_to(38);
    checks++;
    if (obs !== {2'd3, 4'b1111, 4'h1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL en_resume_tick got %b exp %b", obs, {2'd3, 4'b1111, 4'h1, 1'b0, 1'b0});
    end
  endtask

  // Asynchronous reset mid-slot blanks immediately; scan restarts from 0.
  task automatic test_async_reset();
    int          e [3] = '{1, 4, 16};
    logic [11:0] x [3] = '{
      {2'd0, 4'b1110, 4'h0, 1'b0, 1'b0},
      {2'd1, 4'b1111, 4'h0, 1'b0, 1'b0},
      {2'd0, 4'b1111, 4'h4, 1'b0, 1'b0}
    };
    hexs = 16'h1234; point = '0; les = '0;
    do_reset();
    run_to(17);
    checks++;
    if (obs !== {2'd0, 4'b1110, 4'h4, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL arst_before got %b exp %b", obs, {2'd0, 4'b1110, 4'h4, 1'b0, 1'b0});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== {2'd0, 4'b1111, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL arst_immediate got %b exp %b", obs, {2'd0, 4'b1111, 4'h0, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst_n   = 1'b1;
    edge_no = 0;
    for (int i = 0; i < 3; i++) begin
      run_to(e[i]);
      checks++;
      if (obs !== x[i]) begin
        errors++;
        $display("FAIL arst_edge%0d got %b exp %b", e[i], obs, x[i]);
      end
    end
  endtask

  // Single digit: every tick wraps, anode pulses off during the dead cycle.
  task automatic test_single_digit();
    int         e [5] = '{1, 3, 4, 5, 8};
    logic [7:0] x [5] = '{
      {1'b0, 1'b0, 4'h0, 1'b0, 1'b0},
      {1'b0, 1'b0, 4'h0, 1'b0, 1'b0},
      {1'b0, 1'b1, 4'h7, 1'b1, 1'b0},
      {1'b0, 1'b0, 4'h7, 1'b1, 1'b0},
      {1'b0, 1'b1, 4'h7, 1'b1, 1'b0}
    };
    hexs1 = 4'h7; point1 = 1'b1; les1 = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_to(e[i]);
      checks++;
      if (obs1 !== x[i]) begin
        errors++;
        $display("FAIL single_edge%0d got %b exp %b", e[i], obs1, x[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_shadow();
    test_blink();
    test_enable();
    test_async_reset();
    test_single_digit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
